// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: signal bundle between the requesters (fetch and
// load/store), the arbiter and the single-ported memory macro.
//
// Handshake: a requester raises *_req with stable address/data and keeps
// them stable until *_gnt is seen high in the same cycle; the access is
// accepted in that cycle. Dropping *_req before a grant withdraws it.
// *_rvalid is a one-cycle pulse that returns exactly one response per grant.
interface mem_port_arbiter_if #(
    parameter int MASK_W = 16
);
    // fetch requester
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // load/store requester
    logic              ls_req;
    logic              ls_wr;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic [MASK_W-1:0] ls_wr_mask;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;

    // memory macro
    logic              mem_en;
    logic              mem_wr;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [MASK_W-1:0] mem_wr_mask;
    logic [31:0]       mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_wr, ls_addr, ls_wdata, ls_wr_mask,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_wr_mask,
        input  mem_rdata
    );

    // requester / memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_wr, ls_addr, ls_wdata, ls_wr_mask,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_wr_mask,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the load/store controller (LS). One access in flight at a time; the
// fixed read latency is tracked and the response is routed to its owner.
//
// Arbitration: LS has priority, but after MAX_WAIT consecutive LS grants
// taken while IF was waiting, IF is forced to win.
// Optional macro ARB_ROUND_ROBIN_EN: replaces the priority/starvation
// scheme with round robin on the most recent winner.
//
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = RD_WAIT, 2 = RESP.
module mem_port_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4,
    parameter int MASK_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    localparam logic [2:0]        LAT_C     = 3'(RD_LAT);
    localparam logic [MASK_W-1:0] MASK_ONES = '1;

    // FSM state and read latency counter
    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_lat_cnt;
    logic [2:0]  w_lat_cnt_nxt;

    // 1 = LS owns the access in flight, 0 = IF
    logic        r_owner_ls;

    // response data and last driven memory address/data
    logic [31:0] r_if_rdata;
    logic [31:0] r_ls_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = LS won the most recent grant
    logic        r_last_ls;
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    // consecutive LS grants taken while IF was waiting
    logic [3:0]  r_starve_cnt;
`endif

    logic        w_grant_ok;
    logic        w_if_win;
    logic        w_ls_win;
    logic        w_if_gnt;
    logic        w_ls_gnt;
    logic        w_any_gnt;
    logic        w_ls_store;
    logic        w_lat_done;
    logic        w_capture;

    // Arbitration: grants only in IDLE or RESP and never while in reset
    always_comb begin
        w_grant_ok = rst_n && ((r_state == ST_IDLE) || (r_state == ST_RESP));
`ifdef ARB_ROUND_ROBIN_EN
        // on contention the requester that did not win last time goes
        w_if_win   = bus.if_req && (!bus.ls_req || r_last_ls);
`else
        // LS wins contention unless IF has waited MAX_WAIT grants
        w_if_win   = bus.if_req && (!bus.ls_req || (r_starve_cnt == MAX_WAIT_C));
`endif
        w_ls_win   = bus.ls_req && !w_if_win;
        w_if_gnt   = w_grant_ok && w_if_win;
        w_ls_gnt   = w_grant_ok && w_ls_win;
        w_any_gnt  = w_if_gnt || w_ls_gnt;
        w_ls_store = w_ls_gnt && bus.ls_wr;
        w_lat_done = (r_lat_cnt == LAT_C);
        w_capture  = (r_state == ST_RD_WAIT) && w_lat_done;
    end

    // Next-state logic: reads wait out the latency, stores answer next cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_ls_store) begin
                    w_state_nxt = ST_RESP;
                end else if (w_any_gnt) begin
                    w_state_nxt   = ST_RD_WAIT;
                    w_lat_cnt_nxt = 3'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (w_lat_done) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and latency counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    // Memory-side and requester-side outputs
    always_comb begin
        bus.if_gnt      = w_if_gnt;
        bus.ls_gnt      = w_ls_gnt;
        bus.mem_en      = w_any_gnt;
        bus.mem_wr      = w_ls_store;
        bus.mem_addr    = r_mem_addr;
        bus.mem_wdata   = r_mem_wdata;
        bus.mem_wr_mask = MASK_ONES;
        if (w_ls_gnt) begin
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
            if (bus.ls_wr) begin
                bus.mem_wr_mask = bus.ls_wr_mask;
            end
        end else if (w_if_gnt) begin
            // fetches never write, so data holds and the mask stays all ones
            bus.mem_addr = bus.if_addr;
        end
        bus.if_rvalid = (r_state == ST_RESP) && !r_owner_ls;
        bus.ls_rvalid = (r_state == ST_RESP) && r_owner_ls;
        bus.if_rdata  = r_if_rdata;
        bus.ls_rdata  = r_ls_rdata;
        o_dbg_state   = r_state;
    end

    // Owner, held address/data and read-data capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner_ls  <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_ls_rdata  <= 32'd0;
        end else begin
            if (w_any_gnt) begin
                r_owner_ls  <= w_ls_gnt;
                r_mem_addr  <= bus.mem_addr;
                r_mem_wdata <= bus.mem_wdata;
            end
            if (w_capture) begin
                if (r_owner_ls) begin
                    r_ls_rdata <= bus.mem_rdata;
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who won the latest grant for the next contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_ls <= 1'b0;
        end else if (w_any_gnt) begin
            r_last_ls <= w_ls_gnt;
        end
    end
`else
    // Count LS grants that IF lost; any IF grant or idle IF clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.if_req || w_if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (w_ls_gnt && (r_starve_cnt != MAX_WAIT_C)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized checks of mem_port_arbiter
// with a latency-accurate memory model and a response scoreboard.
module tb_mem_port_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;
    localparam int MASK_W   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard entry: {owner_is_ls, data}
    logic [32:0] exp_q[$];
    logic [31:0] exp_ls_rdata;
    logic [5:0]  order;

    mem_port_arbiter_if #(.MASK_W(MASK_W)) bus();

    mem_port_arbiter #(
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT),
        .MASK_W   (MASK_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // memory contents seen by reads
    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // memory model: read data valid exactly RD_LAT cycles after mem_en
    logic        pipe_v [RD_LAT] = '{default: 1'b0};
    logic [31:0] pipe_a [RD_LAT] = '{default: 32'd0};
    always @(posedge clk) begin
        pipe_v[0] <= bus.mem_en && !bus.mem_wr;
        pipe_a[0] <= bus.mem_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign bus.mem_rdata = pipe_v[RD_LAT-1] ? data_of(pipe_a[RD_LAT-1]) : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // grant check; on an expected grant the response is queued
    task automatic expect_gnt(input string tag, input logic e_if, input logic e_ls, input logic push);
        chk({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'(e_if));
        chk({tag, "_ls_gnt"}, 32'(bus.ls_gnt), 32'(e_ls));
        if (push && e_if) begin
            exp_q.push_back({1'b0, data_of(bus.if_addr)});
        end else if (push && e_ls) begin
            if (!bus.ls_wr) exp_ls_rdata = data_of(bus.ls_addr);
            exp_q.push_back({1'b1, exp_ls_rdata});
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({tag, "_mask"}, 32'(bus.mem_wr_mask), 32'h0000_FFFF);
        chk({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'd0);
        chk({tag, "_ls_gnt"}, 32'(bus.ls_gnt), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check_quiet(tag);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid), 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // scoreboard: every rvalid pops one expected response
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.if_rvalid === 1'b1 || bus.ls_rvalid === 1'b1) begin
            chk("rvalid_exclusive", 32'(bus.if_rvalid && bus.ls_rvalid), 32'd0);
            chk("rvalid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_owner", 32'(bus.ls_rvalid), 32'(e[32]));
                chk("resp_data", bus.ls_rvalid ? bus.ls_rdata : bus.if_rdata, e[31:0]);
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        int          kind;

        // reset
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = 32'd0;
        bus.ls_wdata = 32'd0; bus.ls_wr_mask = 16'hFFFF;
        exp_ls_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outs("reset");

        // single fetch
        tick();
        rst_n = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        @(negedge clk);
        expect_gnt("fetch", 1'b1, 1'b0, 1'b1);
        chk("fetch_mem_en", 32'(bus.mem_en), 32'd1);
        chk("fetch_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("fetch_mem_addr", bus.mem_addr, 32'h100);
        chk("fetch_mask", 32'(bus.mem_wr_mask), 32'h0000_FFFF);
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("fetch_state_wait", 32'(dbg_state), 32'd1);
        chk("fetch_addr_hold", bus.mem_addr, 32'h100);
        chk("fetch_rv_t1", 32'(bus.if_rvalid), 32'd0);
        check_quiet("fetch_t1");
        tick();
        @(negedge clk);
        chk("fetch_rv_t2", 32'(bus.if_rvalid), 32'd0);
        tick();
        @(negedge clk);
        chk("fetch_rv_t3", 32'(bus.if_rvalid), 32'd1);
        chk("fetch_rdata_t3", bus.if_rdata, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk("fetch_rv_t4", 32'(bus.if_rvalid), 32'd0);
        chk("fetch_rdata_hold", bus.if_rdata, 32'hDEAD_BEEF);
        chk("fetch_state_idle", 32'(dbg_state), 32'd0);

        // contention, loads only, both requests held
`ifdef ARB_ROUND_ROBIN_EN
        order = 6'b010101;
`else
        order = 6'b101111;
`endif
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expect_gnt("contend", !order[k], order[k], 1'b1);
            if (k > 0) chk("contend_prev_ls_rv", 32'(bus.ls_rvalid), 32'(order[k-1]));
            tick();
            if (k == 5) begin
                bus.if_req = 1'b0;
                bus.ls_req = 1'b0;
            end
            @(negedge clk);
            check_quiet("contend_wait1");
            tick();
            @(negedge clk);
            check_quiet("contend_wait2");
            tick();
        end
        @(negedge clk);
        chk("contend_last_ls_rv", 32'(bus.ls_rvalid), 32'(order[5]));
        chk("contend_last_if_rv", 32'(bus.if_rvalid), 32'(!order[5]));

        // store
        tick();
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_addr = 32'h40;
        bus.ls_wdata = 32'h1234_5678; bus.ls_wr_mask = 16'hFFF0;
        @(negedge clk);
        expect_gnt("store", 1'b0, 1'b1, 1'b1);
        chk("store_mem_en", 32'(bus.mem_en), 32'd1);
        chk("store_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("store_addr", bus.mem_addr, 32'h40);
        chk("store_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("store_mask", 32'(bus.mem_wr_mask), 32'h0000_FFF0);
        tick();
        bus.ls_req = 1'b0;
        @(negedge clk);
        chk("store_ack", 32'(bus.ls_rvalid), 32'd1);
        chk("store_ls_rdata", bus.ls_rdata, exp_ls_rdata);
        chk("store_wdata_hold", bus.mem_wdata, 32'h1234_5678);
        check_quiet("store_t1");
        tick();
        @(negedge clk);
        chk("store_ack_once", 32'(bus.ls_rvalid), 32'd0);

        // back-to-back: LS load, IF waits through RD_WAIT
        tick();
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_addr = 32'h500;
        bus.ls_wr_mask = 16'hFFFF;
        @(negedge clk);
        expect_gnt("b2b_ls", 1'b0, 1'b1, 1'b1);
        tick();
        bus.ls_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h600;
        @(negedge clk);
        check_quiet("b2b_wait1");
        tick();
        @(negedge clk);
        check_quiet("b2b_wait2");
        tick();
        @(negedge clk);
        expect_gnt("b2b_if", 1'b1, 1'b0, 1'b1);
        chk("b2b_ls_rv", 32'(bus.ls_rvalid), 32'd1);
        chk("b2b_mem_en", 32'(bus.mem_en), 32'd1);
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("b2b_state_wait", 32'(dbg_state), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("b2b_if_rv", 32'(bus.if_rvalid), 32'd1);
        tick();

        // reset during a load
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_addr = 32'h700;
        @(negedge clk);
        expect_gnt("rst_ld", 1'b0, 1'b1, 1'b0);
        tick();
        bus.ls_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ld_no_rv", 32'(bus.ls_rvalid), 32'd0);
        tick();
        rst_n = 1'b1;
        exp_ls_rdata = 32'd0;
        @(negedge clk);
        check_reset_outs("after_rst");
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h800;
        @(negedge clk);
        expect_gnt("post_rst", 1'b1, 1'b0, 1'b1);
        tick();
        bus.if_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_if_rv", 32'(bus.if_rvalid), 32'd1);
        chk("post_rst_ls_rv", 32'(bus.ls_rvalid), 32'd0);
        tick();

        // randomized single accesses
        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 2);
            ra   = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            if (kind == 0) begin
                bus.if_req = 1'b1; bus.if_addr = ra;
            end else begin
                bus.ls_req = 1'b1; bus.ls_wr = (kind == 2); bus.ls_addr = ra;
                bus.ls_wdata = $urandom; bus.ls_wr_mask = 16'($urandom_range(0, 65535));
            end
            @(negedge clk);
            expect_gnt("rand", kind == 0, kind != 0, 1'b1);
            chk("rand_addr", bus.mem_addr, ra);
            chk("rand_mem_wr", 32'(bus.mem_wr), 32'(kind == 2));
            tick();
            bus.if_req = 1'b0;
            bus.ls_req = 1'b0;
            repeat (RD_LAT + 1) tick();
        end

        // drain outstanding responses
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
